// File: rtl/reg_wb_ctrl.sv
// In-order writeback queue driving the register file write port, with a pending-write scoreboard.
// Optional macro WB_FWD_EN adds FwdA/FwdB and FwdDataA/FwdDataB: youngest-entry forwarding.
module reg_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       EnqValid,
    input  logic                       EnqIsLoad,
    input  logic [4:0]                 EnqRd,
    input  logic [31:0]                EnqData,
    input  logic                       FillValid,
    input  logic [31:0]                FillData,
    input  logic [4:0]                 Ra,
    input  logic [4:0]                 Rb,
    output logic                       Stall,
    output logic                       Full,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       FillErr,
`ifdef WB_FWD_EN
    output logic                       FwdA,
    output logic                       FwdB,
    output logic [31:0]                FwdDataA,
    output logic [31:0]                FwdDataB,
`endif
    output logic [4:0]                 Rw,
    output logic [31:0]                busW,
    output logic                       RegWr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic        valid_q [DEPTH];
    logic        valid_d [DEPTH];
    logic        ready_q [DEPTH];
    logic        ready_d [DEPTH];
    logic [4:0]  rd_q    [DEPTH];
    logic [4:0]  rd_d    [DEPTH];
    logic [31:0] data_q  [DEPTH];
    logic [31:0] data_d  [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          fill_err_q, fill_err_d;

    logic          drain, full, enq, fill_found;
    logic [PW-1:0] fill_idx, scan_idx;
    logic [DEPTH-1:0] match_a, match_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_a[gi] = valid_q[gi] && (rd_q[gi] == Ra);
            assign match_b[gi] = valid_q[gi] && (rd_q[gi] == Rb);
        end
    endgenerate

    // Oldest unfilled load: scan youngest-to-oldest so the oldest hit wins.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        scan_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && !ready_q[scan_idx]) begin
                fill_found = 1'b1;
                fill_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drain   = valid_q[head_q] && ready_q[head_q];
        full    = (count_q == CW'(DEPTH));
        enq     = EnqValid && !full && (EnqIsLoad || (EnqRd != 5'd0));
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (FillValid && fill_found) begin
            ready_d[fill_idx] = 1'b1;
            data_d[fill_idx]  = FillData;
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = !EnqIsLoad;
            rd_d[tail_q]    = EnqRd;
            data_d[tail_q]  = EnqIsLoad ? 32'd0 : EnqData;
            tail_d          = tail_q + 1'b1;
        end
        count_d    = count_q + CW'(enq) - CW'(drain);
        fill_err_d = FillValid && !fill_found;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fill_err_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fill_err_q <= fill_err_d;
        end
    end

    assign RegWr   = drain && (rd_q[head_q] != 5'd0);
    assign Rw      = drain ? rd_q[head_q] : 5'd0;
    assign busW    = drain ? data_q[head_q] : 32'd0;
    assign Full    = full;
    assign Count   = count_q;
    assign FillErr = fill_err_q;

`ifdef WB_FWD_EN
    logic        hit_a, hit_b, rdy_a, rdy_b;
    logic [31:0] yng_data_a, yng_data_b;
    logic [PW-1:0] age_idx;

    // Walk oldest-to-youngest so the last match is the youngest writer.
    always_comb begin
        hit_a = 1'b0; rdy_a = 1'b0; yng_data_a = 32'd0;
        hit_b = 1'b0; rdy_b = 1'b0; yng_data_b = 32'd0;
        age_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_idx = head_q + PW'(i);
            if (match_a[age_idx]) begin
                hit_a = 1'b1; rdy_a = ready_q[age_idx]; yng_data_a = data_q[age_idx];
            end
            if (match_b[age_idx]) begin
                hit_b = 1'b1; rdy_b = ready_q[age_idx]; yng_data_b = data_q[age_idx];
            end
        end
    end

    assign FwdA     = (Ra != 5'd0) && hit_a && rdy_a;
    assign FwdB     = (Rb != 5'd0) && hit_b && rdy_b;
    assign FwdDataA = FwdA ? yng_data_a : 32'd0;
    assign FwdDataB = FwdB ? yng_data_b : 32'd0;
    assign Stall    = ((Ra != 5'd0) && hit_a && !rdy_a) || ((Rb != 5'd0) && hit_b && !rdy_b);
`else
    assign Stall = ((Ra != 5'd0) && (|match_a)) || ((Rb != 5'd0) && (|match_b));
`endif
endmodule
